// File: rtl/mem_stage_pkg.sv
// Shared widths, load-op encodings and bus layouts for the memory stage.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 74;
  localparam int MS_TO_WS_BUS_WD = 70;

  // Load operation encodings carried in the execute-to-memory bus.
  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_H  = 3'b010,
    LD_BU = 3'b101,
    LD_HU = 3'b110
  } ld_op_e;

  // Execute -> memory bus, MSB first.
  typedef struct packed {
    logic        res_from_mem;
    logic [2:0]  ld_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_bus_t;

  // Memory -> write-back bus, MSB first.
  typedef struct packed {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_bus_t;

  // Widen a byte to 32 bits, sign- or zero-extending.
  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  // Widen a halfword to 32 bits, sign- or zero-extending.
  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment and extension. Purely combinational so it can be
// shared with other consumers of raw SRAM read data.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  ld_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword lanes; addr[0] is irrelevant for
  // halfwords because misaligned accesses never reach this stage.
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'b00: byte_sel = rdata[7:0];
      2'b01: byte_sel = rdata[15:8];
      2'b10: byte_sel = rdata[23:16];
      2'b11: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extend the selected lane according to the load type; unknown codes
  // fall back to a full-word load.
  always_comb begin
    data = rdata;
    case (ld_op)
      LD_B:    data = ext8(byte_sel, 1'b1);
      LD_BU:   data = ext8(byte_sel, 1'b0);
      LD_H:    data = ext16(half_sel, 1'b1);
      LD_HU:   data = ext16(half_sel, 1'b0);
      LD_W:    data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction from execute, waits
// for the load response when needed, aligns the data and hands the result
// to write-back. Also exports bypass information to decode.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  // execute side
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_allowin,
  // write-back side
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  // data SRAM response
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  // decode bypass / load-use interlock
  output logic [4:0]                 ms_to_ds_dest,
  output logic [31:0]                ms_to_ds_value,
  output logic                       ms_to_ds_load_busy
);

  es_to_ms_bus_t ms_bus_r;
  ms_to_ws_bus_t ws_bus;
  logic          ms_valid;
  logic          buf_valid;
  logic [31:0]   rdata_buf;

  logic          ms_ready_go;
  logic          ms_fire;
  logic          buf_capture;
  logic [31:0]   load_src;
  logic [31:0]   load_data;
  logic [31:0]   final_result;
  logic          bypass_en;

  // Handshake: a load may leave once its response is live or buffered.
  always_comb begin
    ms_ready_go    = ~ms_bus_r.res_from_mem | data_sram_data_ok | buf_valid;
    ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
    ms_to_ws_valid = ms_valid & ms_ready_go;
    ms_fire        = ms_to_ws_valid & ws_allowin;
    // The response strobe lasts one cycle, so hold the data if write-back
    // is not ready to take it right now.
    buf_capture    = ms_valid & ms_bus_r.res_from_mem & data_sram_data_ok
                     & ~buf_valid & ~ws_allowin;
  end

  // Once buffered, the live read bus may change; always prefer the buffer.
  always_comb begin
    load_src = buf_valid ? rdata_buf : data_sram_rdata;
  end

  mem_load_align u_load_align (
    .ld_op (ms_bus_r.ld_op),
    .addr  (ms_bus_r.alu_result[1:0]),
    .rdata (load_src),
    .data  (load_data)
  );

  // Select result and pack the write-back bus.
  always_comb begin
    final_result        = ms_bus_r.res_from_mem ? load_data : ms_bus_r.alu_result;
    ws_bus.gr_we        = ms_bus_r.gr_we;
    ws_bus.dest         = ms_bus_r.dest;
    ws_bus.final_result = final_result;
    ws_bus.pc           = ms_bus_r.pc;
    ms_to_ws_bus        = ws_bus;
  end

  // Bypass outputs read as zero whenever nothing will be written back.
  always_comb begin
    bypass_en          = ms_valid & ms_bus_r.gr_we;
    ms_to_ds_dest      = bypass_en ? ms_bus_r.dest : 5'd0;
    ms_to_ds_value     = bypass_en ? final_result : 32'd0;
    ms_to_ds_load_busy = ms_valid & ms_bus_r.res_from_mem & ~ms_ready_go;
  end

  // Stage occupancy; refills in the same edge the current instruction leaves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  // Instruction payload register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_bus_r <= '0;
    end else if (es_to_ms_valid & ms_allowin) begin
      ms_bus_r <= es_to_ms_bus_t'(es_to_ms_bus);
    end
  end

  // Load response buffer: capture on a stalled response, release when the
  // instruction is accepted downstream. Capture needs !ws_allowin and
  // release needs ws_allowin, so the two never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      rdata_buf <= 32'd0;
    end else if (buf_capture) begin
      buf_valid <= 1'b1;
      rdata_buf <= data_sram_rdata;
    end else if (ms_fire) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by a
// randomized run against a transaction-level model of the stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        es_to_ms_valid;
  logic [73:0] es_to_ms_bus;
  logic        ms_allowin;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [4:0]  ms_to_ds_dest;
  logic [31:0] ms_to_ds_value;
  logic        ms_to_ds_load_busy;

  int n_assert = 0;
  int n_fail   = 0;

  mem_stage dut (
    .clk                (clk),
    .reset              (reset),
    .es_to_ms_valid     (es_to_ms_valid),
    .es_to_ms_bus       (es_to_ms_bus),
    .ms_allowin         (ms_allowin),
    .ws_allowin         (ws_allowin),
    .ms_to_ws_valid     (ms_to_ws_valid),
    .ms_to_ws_bus       (ms_to_ws_bus),
    .data_sram_data_ok  (data_sram_data_ok),
    .data_sram_rdata    (data_sram_rdata),
    .ms_to_ds_dest      (ms_to_ds_dest),
    .ms_to_ds_value     (ms_to_ds_value),
    .ms_to_ds_load_busy (ms_to_ds_load_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [73:0] mk_es(input logic res, input logic [2:0] op, input logic we,
                                        input logic [4:0] dest, input logic [31:0] alu,
                                        input logic [31:0] pc);
    return {res, op, we, dest, alu, pc};
  endfunction

  function automatic logic [69:0] mk_ws(input logic we, input logic [4:0] dest,
                                        input logic [31:0] res, input logic [31:0] pc);
    return {we, dest, res, pc};
  endfunction

  // Reference load alignment from the arithmetic definition of each load type.
  function automatic logic [31:0] ref_align(input logic [2:0] op, input logic [1:0] a,
                                            input logic [31:0] d);
    logic [31:0] b;
    logic [31:0] h;
    b = (d >> (int'(a) * 8)) & 32'h0000_00FF;
    h = a[1] ? (d >> 16) : (d & 32'h0000_FFFF);
    case (op)
      3'b001:  return (b >= 32'd128)   ? b - 32'd256   : b;
      3'b101:  return b;
      3'b010:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b110:  return h;
      default: return d;
    endcase
  endfunction

  // Transaction-level model of the instruction held in the stage.
  logic        m_valid;
  logic        m_res;
  logic [2:0]  m_op;
  logic        m_we;
  logic [4:0]  m_dest;
  logic [31:0] m_alu;
  logic [31:0] m_pc;
  logic        m_have;
  logic [31:0] m_data;

  logic [2:0]  ops [5] = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110};
  logic [31:0] pc_q [$];

  initial begin : stim
    logic        n_res, n_we, e_ready, e_valid, e_allow, e_busy;
    logic [2:0]  n_op;
    logic [4:0]  n_dest;
    logic [31:0] n_alu, n_pc, e_final, exp_pc;

    reset             = 1'b1;
    es_to_ms_valid    = 1'b0;
    es_to_ms_bus      = '0;
    ws_allowin        = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    #1;
    chk("rst_allowin", ms_allowin, 1);
    chk("rst_valid", ms_to_ws_valid, 0);
    chk("rst_bus", ms_to_ws_bus, 0);
    chk("rst_ds_dest", ms_to_ds_dest, 0);
    chk("rst_ds_value", ms_to_ds_value, 0);
    chk("rst_busy", ms_to_ds_load_busy, 0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    next_cycle();
    chk("post_rst_bus", ms_to_ws_bus, 0);

    // ALU instruction passes in one cycle
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_es(0, 3'b000, 1, 5'd5, 32'h1234, 32'h1c00_0000);
    #1 chk("alu_allowin", ms_allowin, 1);
    next_cycle();
    es_to_ms_valid = 1'b0;
    #1;
    chk("alu_valid", ms_to_ws_valid, 1);
    chk("alu_bus", ms_to_ws_bus, mk_ws(1, 5'd5, 32'h1234, 32'h1c00_0000));
    chk("alu_ds_dest", ms_to_ds_dest, 5);
    chk("alu_ds_value", ms_to_ds_value, 32'h1234);
    next_cycle();
    chk("alu_empty", ms_to_ws_valid, 0);

    // ld.b then ld.bu back to back, same-cycle data_ok
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_es(1, 3'b001, 1, 5'd7, 32'h1000_0003, 32'h100);
    next_cycle();
    es_to_ms_bus      = mk_es(1, 3'b101, 1, 5'd8, 32'h1000_0003, 32'h104);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF_0000;
    #1;
    chk("ldb_valid", ms_to_ws_valid, 1);
    chk("ldb_bus", ms_to_ws_bus, mk_ws(1, 5'd7, 32'hFFFF_FF80, 32'h100));
    chk("ldb_busy", ms_to_ds_load_busy, 0);
    chk("ldb_allowin", ms_allowin, 1);
    next_cycle();
    es_to_ms_valid = 1'b0;
    #1;
    chk("ldbu_bus", ms_to_ws_bus, mk_ws(1, 5'd8, 32'h0000_0080, 32'h104));
    chk("ldbu_ds_value", ms_to_ds_value, 32'h0000_0080);
    next_cycle();
    data_sram_data_ok = 1'b0;

    // ld.hu with a 3-cycle response delay; next instruction held upstream
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_es(1, 3'b110, 1, 5'd9, 32'h0000_2002, 32'h200);
    next_cycle();
    es_to_ms_bus = mk_es(0, 3'b000, 1, 5'd3, 32'h55, 32'h204);
    for (int i = 0; i < 3; i++) begin
      data_sram_rdata = $urandom;
      #1;
      chk("ldhu_wait_busy", ms_to_ds_load_busy, 1);
      chk("ldhu_wait_allowin", ms_allowin, 0);
      chk("ldhu_wait_valid", ms_to_ws_valid, 0);
      next_cycle();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hBEEF_1234;
    #1;
    chk("ldhu_valid", ms_to_ws_valid, 1);
    chk("ldhu_bus", ms_to_ws_bus, mk_ws(1, 5'd9, 32'h0000_BEEF, 32'h200));
    chk("ldhu_busy_done", ms_to_ds_load_busy, 0);
    chk("ldhu_allowin", ms_allowin, 1);
    next_cycle();
    data_sram_data_ok = 1'b0;
    es_to_ms_valid    = 1'b0;
    #1;
    chk("held_alu_bus", ms_to_ws_bus, mk_ws(1, 5'd3, 32'h55, 32'h204));
    next_cycle();

    // ld.w response while write-back stalls; buffered value must hold
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_es(1, 3'b000, 1, 5'd10, 32'h3000, 32'h300);
    ws_allowin     = 1'b0;
    next_cycle();
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hCAFE_F00D;
    #1;
    chk("ldw_ok_valid", ms_to_ws_valid, 1);
    chk("ldw_ok_bus", ms_to_ws_bus, mk_ws(1, 5'd10, 32'hCAFE_F00D, 32'h300));
    chk("ldw_ok_allowin", ms_allowin, 0);
    next_cycle();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h1111_1111;
    #1;
    chk("ldw_buf_valid", ms_to_ws_valid, 1);
    chk("ldw_buf_bus", ms_to_ws_bus, mk_ws(1, 5'd10, 32'hCAFE_F00D, 32'h300));
    chk("ldw_buf_busy", ms_to_ds_load_busy, 0);
    chk("ldw_buf_allowin", ms_allowin, 0);
    next_cycle();
    ws_allowin      = 1'b1;
    data_sram_rdata = 32'h2222_2222;
    es_to_ms_valid  = 1'b1;
    es_to_ms_bus    = mk_es(1, 3'b000, 1, 5'd11, 32'h3004, 32'h304);
    #1;
    chk("ldw_acc_bus", ms_to_ws_bus, mk_ws(1, 5'd10, 32'hCAFE_F00D, 32'h300));
    chk("ldw_acc_allowin", ms_allowin, 1);
    next_cycle();
    es_to_ms_valid = 1'b0;
    #1;
    chk("buf_cleared_busy", ms_to_ds_load_busy, 1);
    chk("buf_cleared_valid", ms_to_ws_valid, 0);
    next_cycle();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h3333_3333;
    #1 chk("ldw2_bus", ms_to_ws_bus, mk_ws(1, 5'd11, 32'h3333_3333, 32'h304));
    next_cycle();
    data_sram_data_ok = 1'b0;

    // reset during a pending load, then a stray response
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_es(1, 3'b000, 1, 5'd12, 32'h4000, 32'h400);
    next_cycle();
    es_to_ms_valid = 1'b0;
    #1 chk("pend_busy", ms_to_ds_load_busy, 1);
    reset = 1'b1;
    #1;
    chk("midrst_allowin", ms_allowin, 1);
    chk("midrst_valid", ms_to_ws_valid, 0);
    chk("midrst_bus", ms_to_ws_bus, 0);
    chk("midrst_ds_dest", ms_to_ds_dest, 0);
    chk("midrst_busy", ms_to_ds_load_busy, 0);
    next_cycle();
    reset = 1'b0;
    next_cycle();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    chk("stray_valid", ms_to_ws_valid, 0);
    chk("stray_bus", ms_to_ws_bus, 0);
    chk("stray_ds_value", ms_to_ds_value, 0);
    chk("stray_busy", ms_to_ds_load_busy, 0);
    next_cycle();
    data_sram_data_ok = 1'b0;
    #1 chk("stray_after_valid", ms_to_ws_valid, 0);

    // streaming ALU instructions: one retirement per cycle, in order
    ws_allowin = 1'b1;
    for (int i = 0; i < 10; i++) begin
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk_es(0, 3'b000, 1, 5'(i + 1), $urandom, 32'h500 + 32'(i * 4));
      pc_q.push_back(32'h500 + 32'(i * 4));
      #1;
      chk("stream_allowin", ms_allowin, 1);
      if (i > 0) begin
        exp_pc = pc_q.pop_front();
        chk("stream_valid", ms_to_ws_valid, 1);
        chk("stream_pc", ms_to_ws_bus[31:0], exp_pc);
      end
      next_cycle();
    end
    es_to_ms_valid = 1'b0;
    #1;
    exp_pc = pc_q.pop_front();
    chk("stream_last_valid", ms_to_ws_valid, 1);
    chk("stream_last_pc", ms_to_ws_bus[31:0], exp_pc);
    next_cycle();

    // randomized run against the model
    m_valid = 1'b0; m_res = 1'b0; m_op = 3'b000; m_we = 1'b0; m_dest = 5'd0;
    m_alu = 32'd0; m_pc = 32'd0; m_have = 1'b0; m_data = 32'd0;
    for (int c = 0; c < 400; c++) begin
      ws_allowin        = ($urandom_range(0, 3) != 0);
      data_sram_rdata   = $urandom;
      data_sram_data_ok = (m_valid && m_res && !m_have) ? ($urandom_range(0, 2) == 0) : 1'b0;
      n_res  = 1'($urandom_range(0, 1));
      n_op   = ops[$urandom_range(0, 4)];
      n_we   = 1'($urandom_range(0, 1));
      n_dest = 5'($urandom);
      n_alu  = $urandom;
      n_pc   = 32'h8000 + 32'(c * 4);
      es_to_ms_valid = 1'($urandom_range(0, 1));
      es_to_ms_bus   = mk_es(n_res, n_op, n_we, n_dest, n_alu, n_pc);
      #1;
      e_ready = !m_res || m_have || data_sram_data_ok;
      e_valid = m_valid && e_ready;
      e_allow = !m_valid || (e_ready && ws_allowin);
      e_busy  = m_valid && !e_ready;
      e_final = m_res ? ref_align(m_op, m_alu[1:0], m_have ? m_data : data_sram_rdata) : m_alu;
      chk("rnd_allowin", ms_allowin, e_allow);
      chk("rnd_valid", ms_to_ws_valid, e_valid);
      chk("rnd_busy", ms_to_ds_load_busy, e_busy);
      chk("rnd_ds_dest", ms_to_ds_dest, (m_valid && m_we) ? m_dest : 5'd0);
      chk("rnd_ds_value", ms_to_ds_value, (m_valid && m_we) ? e_final : 32'd0);
      if (e_valid) chk("rnd_bus", ms_to_ws_bus, mk_ws(m_we, m_dest, e_final, m_pc));
      if (m_valid && m_res && !m_have && data_sram_data_ok) begin
        m_have = 1'b1;
        m_data = data_sram_rdata;
      end
      if (e_allow) begin
        m_valid = es_to_ms_valid;
        if (es_to_ms_valid) begin
          m_res = n_res; m_op = n_op; m_we = n_we; m_dest = n_dest;
          m_alu = n_alu; m_pc = n_pc; m_have = 1'b0;
        end
      end
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
